// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants, per-channel context type and helpers for the rr pattern detector
package seq_det_pkg;
  localparam int PAT_W_DEF = 2;
  localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 2'b01;
  localparam int MAX_W = 8;
  typedef struct packed {
    logic [MAX_W-2:0] hist;
    logic [2:0] fill;
  } ctx_t;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] mx;
    mx = (32'd1 << w) - 32'd1;
    return v >= mx ? mx : v + 32'd1;
  endfunction
endpackage

// File: rtl/seq_det_engine.sv
// seq_det_engine: one Mealy step of the pattern detector on a saved channel context
module seq_det_engine import seq_det_pkg::*; #(
  parameter int PAT_W = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF
) (
  input  ctx_t ctx_in,
  input  logic din,
  output ctx_t ctx_out,
  output logic hit
);
  localparam int H = PAT_W - 1;
  logic [PAT_W-1:0] win;
  logic unused_hi;
  assign unused_hi = ^{ctx_in.hist, 1'b0};
  assign win = {ctx_in.hist[H-1:0], din};
  assign hit = ctx_in.fill == 3'(H) && win == PATTERN;
  always_comb begin
    ctx_out = '0;
    ctx_out.hist[H-1:0] = win[H-1:0];
    ctx_out.fill = ctx_in.fill == 3'(H) ? ctx_in.fill : ctx_in.fill + 3'd1;
  end
endmodule

// File: rtl/seq_det_rr_sched.sv
// seq_det_rr_sched: round-robin sharing of one serial pattern detector across NCH channels
module seq_det_rr_sched import seq_det_pkg::*; #(
  parameter int NCH = 4,
  parameter int PAT_W = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] bit_in,
  output logic [NCH-1:0] gnt,
  input  logic [NCH-1:0] clr_ch,
  output logic hit_vld,
  output logic [ch_w(NCH)-1:0] hit_ch,
  input  logic [ch_w(NCH)-1:0] rd_ch,
  output logic [CNT_W-1:0] rd_cnt
);
  localparam int CW = ch_w(NCH);
  logic [CW-1:0] ptr, gidx;
  logic xfer, hit, win;
  ctx_t ctx [NCH];
  ctx_t nxt;
  logic [CNT_W-1:0] cnt [NCH];
  // scan downward so the last match found is the first requester at or after ptr
  always_comb begin
    gidx = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NCH]) gidx = CW'((int'(ptr) + k) % NCH);
  end
  assign xfer = en && !rst && |req;
  assign gnt = xfer ? NCH'(1) << gidx : '0;
  assign win = xfer && hit && !clr_ch[gidx];
  assign rd_cnt = int'(rd_ch) < NCH ? cnt[rd_ch] : '0;
  seq_det_engine #(.PAT_W(PAT_W), .PATTERN(PATTERN)) u_engine (
    .ctx_in(ctx[gidx]),
    .din(bit_in[gidx]),
    .ctx_out(nxt),
    .hit(hit)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= '0;
      hit_vld <= 1'b0;
      hit_ch <= '0;
      for (int i = 0; i < NCH; i++) begin
        ctx[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      hit_vld <= win;
      if (win) hit_ch <= gidx;
      if (xfer) ptr <= gidx == CW'(NCH - 1) ? '0 : gidx + 1'b1;
      for (int i = 0; i < NCH; i++)
        if (clr_ch[i]) begin
          ctx[i] <= '0;
          cnt[i] <= '0;
        end else if (xfer && gidx == CW'(i)) begin
          ctx[i] <= nxt;
          if (hit) cnt[i] <= CNT_W'(sat_inc(32'(cnt[i]), CNT_W));
        end
    end
endmodule

// File: tb/tb_seq_det_rr_sched.sv
// tb_seq_det_rr_sched: directed and random stimulus against a bit-queue reference model with a hit scoreboard
module tb_seq_det_rr_sched;
  localparam int NCH = 4;
  localparam int PAT_W = 2;
  localparam int CNT_W = 4;
  localparam logic [PAT_W-1:0] PATTERN = 2'b01;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [NCH-1:0] req = '0;
  logic [NCH-1:0] bit_in = '0;
  logic [NCH-1:0] clr_ch = '0;
  logic [NCH-1:0] gnt;
  logic hit_vld;
  logic [1:0] hit_ch;
  logic [1:0] rd_ch = '0;
  logic [CNT_W-1:0] rd_cnt;
  int errors = 0;
  int checks = 0;
  int edges = 0;
  typedef struct {
    int ch;
    int due;
  } exp_t;
  exp_t q[$];
  int mptr;
  int mcnt[NCH];
  int mh[NCH][$];

  seq_det_rr_sched #(.NCH(NCH), .PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .bit_in(bit_in), .gnt(gnt),
    .clr_ch(clr_ch), .hit_vld(hit_vld), .hit_ch(hit_ch), .rd_ch(rd_ch), .rd_cnt(rd_cnt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edges);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] r, input logic [3:0] b, input logic [3:0] c);
    @(posedge clk);
    #2;
    rst = 1'b0;
    en = e;
    req = r;
    bit_in = b;
    clr_ch = c;
  endtask

  // reference model: inputs are stable at the falling edge, the transfer happens on the next rising edge
  always @(negedge clk) begin
    int g, v;
    bit mhit;
    if (rst) begin
      mptr = 0;
      q.delete();
      for (int i = 0; i < NCH; i++) begin
        mcnt[i] = 0;
        mh[i].delete();
      end
    end else begin
      g = -1;
      if (en)
        for (int k = NCH - 1; k >= 0; k--)
          if (req[(mptr + k) % NCH]) g = (mptr + k) % NCH;
      chk("gnt", int'(gnt), g < 0 ? 0 : (1 << g));
      chk("rd_cnt", int'(rd_cnt), mcnt[rd_ch]);
      if (g >= 0) begin
        mh[g].push_back(int'(bit_in[g]));
        if (mh[g].size() > PAT_W) void'(mh[g].pop_front());
        v = 0;
        for (int k = 0; k < mh[g].size(); k++) v = v * 2 + mh[g][k];
        mhit = mh[g].size() == PAT_W && v == int'(PATTERN) && !clr_ch[g];
        mptr = (g + 1) % NCH;
        if (mhit) begin
          if (mcnt[g] < (1 << CNT_W) - 1) mcnt[g]++;
          q.push_back('{g, edges + 1});
        end
      end
      for (int i = 0; i < NCH; i++)
        if (clr_ch[i]) begin
          mcnt[i] = 0;
          mh[i].delete();
        end
    end
  end

  // monitor: every hit pulse must match the oldest expected hit, on the edge it was due
  always @(posedge clk) begin
    #1;
    edges++;
    if (hit_vld) begin
      if (q.size() == 0) chk("hit_vld_spurious", 1, 0);
      else begin
        chk("hit_ch", int'(hit_ch), q[0].ch);
        chk("hit_edge", edges, q[0].due);
        void'(q.pop_front());
      end
    end else if (q.size() != 0 && q[0].due <= edges) begin
      chk("hit_vld_missing", 0, 1);
      void'(q.pop_front());
    end
  end

  initial begin
    @(posedge clk);
    #3;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_hit_vld", int'(hit_vld), 0);
    chk("rst_hit_ch", int'(hit_ch), 0);
    chk("rst_rd_cnt", int'(rd_cnt), 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 4'b1111, 4'b0000, 4'b0000);
      #1 chk("rotate_gnt", int'(gnt), 1 << (i % NCH));
    end
    step(1, 4'b0001, 4'b0000, 4'b0000);
    step(1, 4'b0001, 4'b0001, 4'b0000);
    step(1, 4'b0001, 4'b0001, 4'b0000);
    step(1, 4'b0001, 4'b0000, 4'b0000);
    step(1, 4'b0001, 4'b0001, 4'b0000);
    step(1, 4'b0000, 4'b0000, 4'b0000);
    rd_ch = 2'd0;
    step(1, 4'b0000, 4'b0000, 4'b0000);
    #1 chk("ch0_cnt", int'(rd_cnt), 2);
    step(1, 4'b0010, 4'b0000, 4'b0000);
    step(1, 4'b0100, 4'b0100, 4'b0000);
    step(1, 4'b0100, 4'b0000, 4'b0000);
    step(1, 4'b0100, 4'b0100, 4'b0000);
    step(1, 4'b0000, 4'b0000, 4'b0000);
    rd_ch = 2'd1;
    #1 chk("iso_ch1_cnt", int'(rd_cnt), 0);
    step(1, 4'b0010, 4'b0000, 4'b0000);
    step(1, 4'b0010, 4'b0010, 4'b0010);
    step(1, 4'b0010, 4'b0010, 4'b0000);
    step(1, 4'b0000, 4'b0000, 4'b0000);
    #1 chk("clr_ch1_cnt", int'(rd_cnt), 0);
    for (int i = 0; i < 40; i++) step(1, 4'b1000, (i % 2) ? 4'b1000 : 4'b0000, 4'b0000);
    step(1, 4'b0000, 4'b0000, 4'b0000);
    rd_ch = 2'd3;
    #1 chk("sat_ch3_cnt", int'(rd_cnt), 15);
    step(1, 4'b0001, 4'b0000, 4'b0000);
    step(1, 4'b0001, 4'b0001, 4'b0000);
    #1 rst = 1'b1;
    #1 chk("midrst_gnt", int'(gnt), 0);
    chk("midrst_hit_vld", int'(hit_vld), 0);
    for (int r = 0; r < NCH; r++) begin
      rd_ch = 2'(r);
      #1 chk("midrst_rd_cnt", int'(rd_cnt), 0);
    end
    step(1, 4'b1111, 4'b0001, 4'b0000);
    #1 chk("midrst_ptr_gnt", int'(gnt), 1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(7) != 0, 4'($urandom), 4'($urandom), $urandom_range(11) == 0 ? 4'($urandom) : 4'b0000);
      rd_ch = 2'($urandom);
    end
    for (int i = 0; i < 4; i++) step(0, 4'b0000, 4'b0000, 4'b0000);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
